// File: rtl/dsp_m36_serializer.sv
// dsp_m36_serializer: splits each 36-bit product word into two 18-bit beats.
// Ports:
//   clk, reset (sync, active-high), ce (clock enable, freezes all state)
//   in_data[35:0] / in_valid / in_ready   : word input handshake
//   out_data[17:0] / out_valid / out_ready : beat output handshake
//   out_last     : high on the second (final) beat of a word
//   word_count   : completed words, wraps at 16 bits
//   out_parity   : even parity of out_data (only with DSP_M36_SER_PARITY_EN)
// Parameter LSB_FIRST: 1 sends in_data[17:0] first, 0 sends in_data[35:18] first.
// Optional feature macro: DSP_M36_SER_PARITY_EN adds the out_parity port.

module dsp_m36_serializer #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [35:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [17:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] word_count
`ifdef DSP_M36_SER_PARITY_EN
    ,
    output logic        out_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [35:0] hold;
    logic [15:0] wcount;
    logic        in_xfer;
    logic        out_xfer;
    logic [17:0] first_half;
    logic [17:0] second_half;

    // Both handshakes are already qualified by ce through in_ready/out_valid.
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_xfer) begin
                    state_next = BEAT0;
                end
            end
            BEAT0: begin
                if (out_xfer) begin
                    state_next = BEAT1;
                end
            end
            BEAT1: begin
                // A new word can only arrive together with the final beat.
                if (out_xfer) begin
                    state_next = in_xfer ? BEAT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Hold register and completed-word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= 36'd0;
        end else if (in_xfer) begin
            hold <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcount <= 16'd0;
        end else if (out_xfer && state == BEAT1) begin
            wcount <= wcount + 16'd1;
        end
    end

    // Output logic
    always_comb begin
        if (LSB_FIRST != 0) begin
            first_half  = hold[17:0];
            second_half = hold[35:18];
        end else begin
            first_half  = hold[35:18];
            second_half = hold[17:0];
        end
        in_ready   = ce & ((state == IDLE) | ((state == BEAT1) & out_ready));
        out_valid  = ce & (state != IDLE);
        out_last   = (state == BEAT1);
        out_data   = (state == BEAT1) ? second_half : first_half;
        word_count = wcount;
    end

`ifdef DSP_M36_SER_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: doc/dsp_m36_serializer.md
DSP_M36_SERIALIZER -- requirements
Module: dsp_m36_serializer

Interface
REQ-001 Parameter LSB_FIRST, default 1; 1 = beat 0 carries in_data[17:0], 0 = beat 0 carries in_data[35:18].
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  clock enable; when low, all state is frozen.
REQ-005 in_data  input  36  product word from the M-register stage.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data  output  18  current half-word beat.
REQ-009 out_valid  output  1  out_data is valid this cycle.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 out_last  output  1  high on the second (final) beat of a word.
REQ-012 word_count  output  16  number of completed words (both beats transferred).
REQ-013 out_parity  output  1  even parity of out_data; present only with DSP_M36_SER_PARITY_EN.

Function
REQ-014 Input transfer SHALL occur on in_valid & in_ready; output transfer SHALL occur on out_valid & out_ready.
REQ-015 FSM states SHALL be IDLE, BEAT0 and BEAT1, with a 36-bit hold register.
REQ-016 In IDLE, an input transfer SHALL capture in_data into the hold register and move to BEAT0.
REQ-017 In BEAT0, an output transfer SHALL move to BEAT1; with no transfer the state and out_data SHALL be held.
REQ-018 In BEAT1 with an output transfer, the FSM SHALL move to BEAT0 if an input transfer occurs in the same cycle (new word captured), else to IDLE.
REQ-019 in_ready SHALL be combinational: ce & (state==IDLE | (state==BEAT1 & out_ready)).
REQ-020 out_valid SHALL be ce & (state!=IDLE).
REQ-021 out_last SHALL be (state==BEAT1).
REQ-022 out_data SHALL be the hold-register half selected by state and LSB_FIRST.
REQ-023 Latency SHALL be: beat 0 valid in the cycle after input capture.
REQ-024 Sustained throughput SHALL be one word per 2 cycles with out_ready held high and in_valid held high.
REQ-025 word_count SHALL increment by 1 on each BEAT1 output transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 When ce=0, no input or output transfer SHALL occur, and state, hold register and word_count SHALL hold.
REQ-027 Changes to in_data while in_ready=0 SHALL have no effect.
REQ-028 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE, the hold register to 0, and word_count to 0.
REQ-030 After reset, out_valid and out_last SHALL be 0; out_data SHALL be 0 and out_parity 0.
REQ-031 Reset SHALL take priority over ce and over any handshake.
REQ-032 Reset asserted mid-word SHALL discard the partially sent word without incrementing word_count.

Configuration
REQ-033 Macro DSP_M36_SER_PARITY_EN defined: out_parity port SHALL exist and SHALL equal the XOR of out_data, combinational, valid whenever out_valid=1.
REQ-034 Macro undefined: the out_parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Scenario: reset, ce=1, out_ready=1, send in_data=36'h9_1234_5678 with LSB_FIRST=1 -> beat 0 out_data=18'h05678 with out_last=0, then beat 1 out_data=18'h2448D with out_last=1; word_count=1.
REQ-036 Scenario: LSB_FIRST=0, same word -> beat 0 out_data=18'h2448D, then beat 1 out_data=18'h05678.
REQ-037 Scenario: out_ready=0 for 5 cycles during BEAT0 -> out_data held and in_ready=0; on release, beats complete in order.
REQ-038 Scenario: 4 back-to-back words with in_valid=1 and out_ready=1 -> 8 beats in 8 consecutive cycles; word_count=4.
REQ-039 Scenario: ce=0 for 3 cycles in BEAT1 -> out_valid=0 and no change to state or word_count; resumes on ce=1. Reset asserted in BEAT0 -> IDLE next cycle, word_count unchanged at its reset value 0.
REQ-040 Scenario: word_count preloaded to 0xFFFF by sending 65535 words, then one more word -> word_count=0x0000; with the parity macro enabled, out_data=18'h00007 -> out_parity=1.
